// File: rtl/fft_pkg.sv
// Shared FFT definitions: quarter-wave cosine table, clog2 helper,
// and the twiddle pair type.
package fft_pkg;

    localparam int TW_W_DEF = 9;
    localparam int QTAB_BITS = 16;
    localparam int QTAB_N = 64;

    typedef struct packed {
        logic signed [TW_W_DEF-1:0] w_r;
        logic signed [TW_W_DEF-1:0] w_i;
    } tw_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // trunc(2^16 * cos(2*pi*k/64)), k = 0..16. Smaller N decimate this
    // table, and truncating it further by a right shift equals truncating
    // the exact product at the narrower scale.
    function automatic logic [QTAB_BITS:0] qtab(input logic [4:0] k);
        logic [QTAB_BITS:0] v;
        v = '0;
        case (k)
            5'd0:  v = 17'd65536;
            5'd1:  v = 17'd65220;
            5'd2:  v = 17'd64276;
            5'd3:  v = 17'd62714;
            5'd4:  v = 17'd60547;
            5'd5:  v = 17'd57797;
            5'd6:  v = 17'd54491;
            5'd7:  v = 17'd50660;
            5'd8:  v = 17'd46340;
            5'd9:  v = 17'd41575;
            5'd10: v = 17'd36409;
            5'd11: v = 17'd30893;
            5'd12: v = 17'd25079;
            5'd13: v = 17'd19024;
            5'd14: v = 17'd12785;
            5'd15: v = 17'd6423;
            default: v = 17'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Sample handshake into the twiddle generator and twiddle stream out.
interface twiddle_gen_if #(
    parameter int TW_W = 9
) ();
    logic                   start_i;
    logic                   valid_i;
    logic                   inverse_i;
    logic signed [TW_W-1:0] w_r;
    logic signed [TW_W-1:0] w_i;
    logic                   valid_o;
    logic                   last_o;

    modport master (
        output start_i, valid_i, inverse_i,
        input  w_r, w_i, valid_o, last_o
    );

    modport slave (
        input  start_i, valid_i, inverse_i,
        output w_r, w_i, valid_o, last_o
    );
endinterface

// File: rtl/twiddle_qrom.sv
// Combinational quarter-wave lookup: index i -> cos[i], sin[i]
// at N_POINTS resolution and TW_W scale.
module twiddle_qrom
    import fft_pkg::*;
#(
    parameter int N_POINTS = 32,
    parameter int TW_W     = 9
) (
    input  logic [clog2(N_POINTS)-3:0] idx,
    output logic signed [TW_W-1:0]     cos_v,
    output logic signed [TW_W-1:0]     sin_v
);
    localparam int LOGN = clog2(N_POINTS);
    localparam int SH   = clog2(QTAB_N) - LOGN;
    localparam int SHR  = QTAB_BITS - (TW_W - 2);

    logic [4:0]         k;
    logic [4:0]         kc;
    logic [QTAB_BITS:0] cos_full;
    logic [QTAB_BITS:0] sin_full;

    always_comb begin
        k        = 5'(idx) << SH;
        kc       = 5'd16 - k;
        cos_full = qtab(k);
        sin_full = qtab(kc);
    end

    assign cos_v = TW_W'(cos_full >> SHR);
    assign sin_v = TW_W'(sin_full >> SHR);

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle generator for one MDC FFT stage: exponent schedule,
// quadrant symmetry and conjugate mode, latency 2.
module twiddle_gen
    import fft_pkg::*;
#(
    parameter int N_POINTS = 32,
    parameter int TW_W     = 9,
    parameter int STAGE    = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    twiddle_gen_if.slave bus
);
    localparam int LOGN = clog2(N_POINTS);
    localparam int CW   = LOGN - 1;
    localparam int QW   = LOGN - 2;

    if (!(N_POINTS == 8 || N_POINTS == 16 ||
          N_POINTS == 32 || N_POINTS == 64)) begin : g_bad_n
        $error("twiddle_gen: unsupported N_POINTS %0d", N_POINTS);
    end
    if (STAGE < 0 || STAGE > LOGN - 2) begin : g_bad_stage
        $error("twiddle_gen: illegal STAGE %0d", STAGE);
    end
    if (TW_W < 3 || TW_W > QTAB_BITS + 2) begin : g_bad_w
        $error("twiddle_gen: unsupported TW_W %0d", TW_W);
    end

    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_use;
    logic [CW-1:0]          e;
    logic                   last;
    logic                   q_p1;
    logic [QW-1:0]          i_p1;
    logic                   inv_p1;
    logic                   valid_p1;
    logic                   last_p1;
    logic signed [TW_W-1:0] cos_v;
    logic signed [TW_W-1:0] sin_v;
    logic signed [TW_W-1:0] r_nx;
    logic signed [TW_W-1:0] i_nx;

    // (cnt mod L/2) << STAGE is exactly cnt << STAGE kept to CW bits
    always_comb begin
        cnt_use = bus.start_i ? '0 : cnt;
        e       = cnt_use << STAGE;
        last    = (cnt_use == CW'(N_POINTS / 2 - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus.start_i) begin
            cnt <= bus.valid_i ? CW'(1) : '0;
        end else if (bus.valid_i) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p1     <= 1'b0;
            i_p1     <= '0;
            inv_p1   <= 1'b0;
            valid_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            q_p1     <= e[CW-1];
            i_p1     <= e[CW-2:0];
            inv_p1   <= bus.inverse_i;
            valid_p1 <= bus.valid_i;
            last_p1  <= bus.valid_i & last;
        end
    end

    twiddle_qrom #(
        .N_POINTS(N_POINTS),
        .TW_W    (TW_W)
    ) u_qrom (
        .idx  (i_p1),
        .cos_v(cos_v),
        .sin_v(sin_v)
    );

    always_comb begin
        r_nx = cos_v;
        i_nx = -sin_v;
        unique case (1'b1)
            q_p1: begin
                r_nx = -sin_v;
                i_nx = -cos_v;
            end
            default: begin
                r_nx = cos_v;
                i_nx = -sin_v;
            end
        endcase
        if (inv_p1) i_nx = -i_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.w_r     <= '0;
            bus.w_i     <= '0;
            bus.valid_o <= 1'b0;
            bus.last_o  <= 1'b0;
        end else begin
            if (valid_p1) begin
                bus.w_r <= r_nx;
                bus.w_i <= i_nx;
            end
            bus.valid_o <= valid_p1;
            bus.last_o  <= last_p1;
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: STAGE 0 and STAGE 2 instances
// share one stimulus stream and are checked against a cos/sin model.
module tb_twiddle_gen;
    import fft_pkg::*;

    localparam int N   = 32;
    localparam int W   = 9;
    localparam int LAT = 3;
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int  stamp;
        logic last;
        tw_t w;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic valid = 1'b0;
    logic inv = 1'b0;

    int total = 0;
    int bad = 0;
    int negc = 0;
    int mcnt = 0;

    exp_t sb[2][$];
    logic signed [W-1:0] hold_r[2];
    logic signed [W-1:0] hold_i[2];

    always #5 clk = ~clk;

    twiddle_gen_if #(.TW_W(W)) bus0 ();
    twiddle_gen_if #(.TW_W(W)) bus1 ();

    assign bus0.start_i   = start;
    assign bus0.valid_i   = valid;
    assign bus0.inverse_i = inv;
    assign bus1.start_i   = start;
    assign bus1.valid_i   = valid;
    assign bus1.inverse_i = inv;

    twiddle_gen #(.N_POINTS(N), .TW_W(W), .STAGE(0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    twiddle_gen #(.N_POINTS(N), .TW_W(W), .STAGE(2)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    task automatic cmp(input string nm, input int id, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %0d, want %0d", nm, id, $time, got, want);
        end
    endtask

    // W = e^(-j*2*pi*e/N) scaled by 2^(W-2), truncated toward zero
    function automatic exp_t model(input int c, input int stg, input logic iv, input int st);
        exp_t x;
        int   e;
        int   r;
        int   im;
        real  unity;
        real  ang;
        e     = (c % ((N >> stg) / 2)) << stg;
        unity = real'(1 << (W - 2));
        ang   = 2.0 * PI * real'(e) / real'(N);
        r     = $rtoi(unity * $cos(ang));
        im    = -$rtoi(unity * $sin(ang));
        if (iv) im = -im;
        x.stamp = st;
        x.last  = (c == N / 2 - 1);
        x.w.w_r = r[W-1:0];
        x.w.w_i = im[W-1:0];
        return x;
    endfunction

    task automatic mon(input int id, input logic vo, input logic lo,
                       input logic signed [W-1:0] wr, input logic signed [W-1:0] wi);
        exp_t x;
        if (!rst_n) begin
            sb[id].delete();
            cmp("rst_valid", id, int'(vo), 0);
            cmp("rst_last", id, int'(lo), 0);
            cmp("rst_w_r", id, wr, 0);
            cmp("rst_w_i", id, wi, 0);
            hold_r[id] = '0;
            hold_i[id] = '0;
            return;
        end
        while (sb[id].size() > 0 && negc - sb[id][0].stamp > LAT) begin
            x = sb[id].pop_front();
            cmp("missing_out", id, negc - x.stamp, LAT);
        end
        if (vo) begin
            if (sb[id].size() == 0) begin
                cmp("spurious_valid", id, int'(vo), 0);
            end else begin
                x = sb[id].pop_front();
                cmp("latency", id, negc - x.stamp, LAT);
                cmp("w_r", id, wr, x.w.w_r);
                cmp("w_i", id, wi, x.w.w_i);
                cmp("last", id, int'(lo), int'(x.last));
            end
            hold_r[id] = wr;
            hold_i[id] = wi;
        end else begin
            cmp("idle_last", id, int'(lo), 0);
            cmp("hold_w_r", id, wr, hold_r[id]);
            cmp("hold_w_i", id, wi, hold_i[id]);
        end
    endtask

    always @(negedge clk) begin
        negc++;
        mon(0, bus0.valid_o, bus0.last_o, bus0.w_r, bus0.w_i);
        mon(1, bus1.valid_o, bus1.last_o, bus1.w_r, bus1.w_i);
    end

    task automatic step(input logic s, input logic v, input logic iv);
        int cu;
        start = s;
        valid = v;
        inv   = iv;
        if (rst_n) begin
            cu = s ? 0 : mcnt;
            if (v) begin
                sb[0].push_back(model(cu, 0, iv, negc));
                sb[1].push_back(model(cu, 2, iv, negc));
            end
            if (s) mcnt = v ? 1 : 0;
            else if (v) mcnt = (mcnt + 1) % (N / 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        start = 1'b0;
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp("async_clr_w_r", 0, bus0.w_r, 0);
        cmp("async_clr_valid", 0, int'(bus0.valid_o), 0);
        cmp("async_clr_w_r", 1, bus1.w_r, 0);
        cmp("async_clr_valid", 1, int'(bus1.valid_o), 0);
        mcnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        hold_r = '{default: '0};
        hold_i = '{default: '0};
        repeat (6) begin
            @(posedge clk);
            #1;
            valid = ~valid;
            inv   = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 0);

        step(1, 1, 0);
        repeat (15) step(0, 1, 0);

        for (int k = 0; k < 16; k++) step(0, 1, (k == 4 || k == 12));

        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);

        while (mcnt != 7) step(0, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);

        while (mcnt != 9) step(0, 1, 0);
        rst_pulse();
        step(0, 1, 0);
        step(0, 1, 0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 149) == 0) rst_pulse();
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)));
        end

        repeat (5) step(0, 0, 0);
        cmp("drain", 0, sb[0].size(), 0);
        cmp("drain", 1, sb[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
